// File: rtl/fault_diagnoser.sv
// Fault-dictionary consumer: collects a pass/fail syndrome over one pattern set,
// then scans the dictionary ROM and streams out every fault index with that syndrome.
module fault_diagnoser #(
    parameter int unsigned TEST_COUNT  = 148,
    parameter int unsigned OUT_WIDTH   = 22,
    parameter int unsigned FAULT_COUNT = 2230,
    parameter int unsigned IDX_W       = 12,
    parameter int unsigned CNT_W       = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  obs_valid,
    input  logic [OUT_WIDTH-1:0]  obs_out,
    input  logic [OUT_WIDTH-1:0]  exp_out,
    output logic                  dict_rd,
    output logic [IDX_W-1:0]      dict_addr,
    input  logic [TEST_COUNT-1:0] dict_data,
    output logic                  match_valid,
    input  logic                  match_ready,
    output logic [IDX_W-1:0]      match_idx,
    output logic [TEST_COUNT-1:0] syndrome,
    output logic [IDX_W:0]        match_count,
    output logic                  busy,
    output logic                  done,
    output logic                  fault_free
);

    localparam int unsigned MCW = IDX_W + 1;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        READ,
        CMP,
        FIN
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      addr_q, addr_d;
    logic [TEST_COUNT-1:0] syndrome_q, syndrome_d;
    logic                  match_valid_q, match_valid_d;
    logic [IDX_W-1:0]      match_idx_q, match_idx_d;
    logic [MCW-1:0]        match_count_q, match_count_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  fault_free_q, fault_free_d;
    logic                  dict_rd_q, dict_rd_d;

    logic hit;
    logic advance;
    logic miss;

    assign hit     = (dict_data == syndrome_q);
    // A hit may only load the output slot once the previous match has left it.
    assign advance = !hit || !match_valid_q || match_ready;
    assign miss    = (obs_out != exp_out);

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            addr_q        <= '0;
            syndrome_q    <= '0;
            match_valid_q <= 1'b0;
            match_idx_q   <= '0;
            match_count_q <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            fault_free_q  <= 1'b0;
            dict_rd_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            addr_q        <= addr_d;
            syndrome_q    <= syndrome_d;
            match_valid_q <= match_valid_d;
            match_idx_q   <= match_idx_d;
            match_count_q <= match_count_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            fault_free_q  <= fault_free_d;
            dict_rd_q     <= dict_rd_d;
        end
    end

    // Next-state and output logic
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        addr_d        = addr_q;
        syndrome_d    = syndrome_q;
        match_valid_d = match_valid_q && !match_ready;
        match_idx_d   = match_idx_q;
        match_count_d = match_count_q;
        busy_d        = busy_q;
        done_d        = done_q;
        fault_free_d  = fault_free_q;
        dict_rd_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d       = COLLECT;
                    cnt_d         = '0;
                    addr_d        = '0;
                    syndrome_d    = '0;
                    match_count_d = '0;
                    done_d        = 1'b0;
                    fault_free_d  = 1'b0;
                    busy_d        = 1'b1;
                end
            end

            COLLECT: begin
                if (obs_valid) begin
                    for (int unsigned i = 0; i < TEST_COUNT; i++) begin
                        if (CNT_W'(i) == cnt_q) begin
                            syndrome_d[i] = miss;
                        end
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(TEST_COUNT - 1)) begin
                        if (syndrome_d == '0) begin
                            state_d = FIN;
                        end else begin
                            state_d   = READ;
                            addr_d    = '0;
                            dict_rd_d = 1'b1;
                        end
                    end
                end
            end

            READ: begin
                state_d = CMP;
            end

            CMP: begin
                if (advance) begin
                    if (hit) begin
                        match_valid_d = 1'b1;
                        match_idx_d   = addr_q;
                        match_count_d = match_count_q + MCW'(1);
                    end
                    if (addr_q == IDX_W'(FAULT_COUNT - 1)) begin
                        state_d = FIN;
                    end else begin
                        addr_d    = addr_q + IDX_W'(1);
                        state_d   = READ;
                        dict_rd_d = 1'b1;
                    end
                end
            end

            FIN: begin
                if (!match_valid_q || match_ready) begin
                    state_d      = IDLE;
                    busy_d       = 1'b0;
                    done_d       = 1'b1;
                    fault_free_d = (syndrome_q == '0);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign dict_rd     = dict_rd_q;
    assign dict_addr   = addr_q;
    assign match_valid = match_valid_q;
    assign match_idx   = match_idx_q;
    assign syndrome    = syndrome_q;
    assign match_count = match_count_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign fault_free  = fault_free_q;

endmodule

// File: tb/tb_fault_diagnoser.sv
// Scoreboard bench for fault_diagnoser: 8 patterns, 4-entry dictionary {00,05,80,05}.
module tb_fault_diagnoser;

    localparam int unsigned TC = 8;
    localparam int unsigned OW = 22;
    localparam int unsigned FC = 4;
    localparam int unsigned IW = 12;
    localparam int unsigned CW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          obs_valid;
    logic [OW-1:0] obs_out;
    logic [OW-1:0] exp_out;
    logic          dict_rd;
    logic [IW-1:0] dict_addr;
    logic [TC-1:0] dict_data = '0;
    logic          match_valid;
    logic          match_ready;
    logic [IW-1:0] match_idx;
    logic [TC-1:0] syndrome;
    logic [IW:0]   match_count;
    logic          busy;
    logic          done;
    logic          fault_free;

    always #5 clk = ~clk;

    fault_diagnoser #(
        .TEST_COUNT (TC),
        .OUT_WIDTH  (OW),
        .FAULT_COUNT(FC),
        .IDX_W      (IW),
        .CNT_W      (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .obs_valid  (obs_valid),
        .obs_out    (obs_out),
        .exp_out    (exp_out),
        .dict_rd    (dict_rd),
        .dict_addr  (dict_addr),
        .dict_data  (dict_data),
        .match_valid(match_valid),
        .match_ready(match_ready),
        .match_idx  (match_idx),
        .syndrome   (syndrome),
        .match_count(match_count),
        .busy       (busy),
        .done       (done),
        .fault_free (fault_free)
    );

    // Dictionary ROM with one-cycle read latency; data held between reads
    logic [TC-1:0] dict_mem [FC];
    initial begin
        dict_mem[0] = 8'h00;
        dict_mem[1] = 8'h05;
        dict_mem[2] = 8'h80;
        dict_mem[3] = 8'h05;
    end
    always @(posedge clk) begin
        if (dict_rd) dict_data <= dict_mem[dict_addr[1:0]];
    end

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned exp_q[$];
    int unsigned rd_pulses = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every accepted match, checks idx stability under backpressure
    initial begin
        logic          armed;
        logic [IW-1:0] held_idx;
        int unsigned   e;
        armed = 1'b0;
        held_idx = '0;
        forever begin
            @(negedge clk);
            if (dict_rd) rd_pulses++;
            if (match_valid) begin
                if (armed) check("idx_stable", 32'(match_idx), 32'(held_idx));
                if (match_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_match: got idx %0d, expected no match", match_idx);
                    end else begin
                        e = exp_q.pop_front();
                        check("match_idx", 32'(match_idx), e);
                    end
                    armed = 1'b0;
                end else begin
                    armed    = 1'b1;
                    held_idx = match_idx;
                end
            end else begin
                armed = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start a run, then replay 8 patterns; bit i of syn marks pattern i as failing
    task automatic run_collect(input logic [TC-1:0] syn, input int gap, input bit poke_start);
        rd_pulses = 0;
        start     = 1'b1;
        obs_valid = 1'b1;
        exp_out   = OW'(32'h3C0F1);
        obs_out   = ~exp_out;
        tick();
        start = 1'b0;
        for (int i = 0; i < int'(TC); i++) begin
            obs_valid = 1'b1;
            exp_out   = OW'(32'h155AA3 + i * 7);
            obs_out   = syn[i] ? (exp_out ^ OW'(1 << (i % int'(OW)))) : exp_out;
            tick();
            obs_valid = 1'b0;
            obs_out   = ~exp_out;
            for (int g = 0; g < gap; g++) begin
                if (poke_start && g == 0) start = 1'b1;
                tick();
                start = 1'b0;
            end
        end
    endtask

    task automatic wait_done(input string name, input int budget);
        int n;
        n = 0;
        while (n < budget) begin
            @(negedge clk);
            n++;
            if (done) break;
        end
        check(name, 32'(done), 32'd1);
    endtask

    task automatic end_checks(input string tag, input logic [TC-1:0] syn, input int mcount,
                              input bit ff, input int rds);
        check({tag, "_syndrome"}, 32'(syndrome), 32'(syn));
        check({tag, "_match_count"}, 32'(match_count), 32'(mcount));
        check({tag, "_fault_free"}, 32'(fault_free), 32'(ff));
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_queue_left"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_dict_reads"}, 32'(rd_pulses), 32'(rds));
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_syndrome"}, 32'(syndrome), 32'd0);
        check({tag, "_match_count"}, 32'(match_count), 32'd0);
        check({tag, "_dict_addr"}, 32'(dict_addr), 32'd0);
        check({tag, "_match_idx"}, 32'(match_idx), 32'd0);
        check({tag, "_flags"}, {27'd0, dict_rd, match_valid, busy, done, fault_free}, 32'd0);
    endtask

    initial begin
        int  cyc;
        bit  seen;
        rst         = 1'b1;
        start       = 1'b0;
        obs_valid   = 1'b0;
        obs_out     = '0;
        exp_out     = '0;
        match_ready = 1'b1;
        repeat (3) tick();
        reset_checks("reset");
        rst = 1'b0;
        tick();

        // Failing patterns 0 and 2: faults 1 and 3 match
        exp_q.push_back(1);
        exp_q.push_back(3);
        run_collect(8'h05, 0, 1'b0);
        wait_done("basic_done", 100);
        end_checks("basic", 8'h05, 2, 1'b0, 4);

        // Fault-free device: no dictionary scan at all
        tick();
        run_collect(8'h00, 0, 1'b0);
        wait_done("ff_done", 100);
        end_checks("ff", 8'h00, 0, 1'b1, 0);

        // Syndrome absent from dictionary; READ..CMP x4 plus the FIN cycle before done
        tick();
        run_collect(8'h40, 0, 1'b0);
        cyc  = 0;
        seen = 1'b0;
        for (int k = 0; k < 100 && !done; k++) begin
            @(negedge clk);
            if (dict_rd) seen = 1'b1;
            if (seen && !done) cyc++;
        end
        check("nomatch_done", 32'(done), 32'd1);
        check("nomatch_scan_cycles", 32'(cyc), 32'(2 * FC + 1));
        end_checks("nomatch", 8'h40, 0, 1'b0, 4);

        // Backpressure: hold ready low for 10 cycles after the first match
        tick();
        match_ready = 1'b0;
        exp_q.push_back(1);
        exp_q.push_back(3);
        run_collect(8'h05, 0, 1'b0);
        cyc = 0;
        while (!match_valid && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("stall_first_valid", 32'(match_valid), 32'd1);
        repeat (10) @(negedge clk);
        check("stall_addr", 32'(dict_addr), 32'd3);
        check("stall_no_rd", 32'(dict_rd), 32'd0);
        check("stall_idx", 32'(match_idx), 32'd1);
        check("stall_reads", 32'(rd_pulses), 32'd4);
        @(posedge clk);
        #1;
        match_ready = 1'b1;
        wait_done("stall_done", 100);
        end_checks("stall", 8'h05, 2, 1'b0, 4);

        // Patterns every 3rd cycle with start pulses during collection and scan
        tick();
        exp_q.push_back(1);
        exp_q.push_back(3);
        run_collect(8'h05, 2, 1'b1);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("gap_done", 100);
        end_checks("gap", 8'h05, 2, 1'b0, 4);

        // Reset while stalled in CMP with a match pending
        tick();
        match_ready = 1'b0;
        exp_q.push_back(1);
        exp_q.push_back(3);
        run_collect(8'h05, 0, 1'b0);
        cyc = 0;
        while (!(match_valid && dict_addr == IW'(3) && !dict_rd) && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("rst_reached_stall", 32'(match_valid), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        reset_checks("midrst");
        match_ready = 1'b1;
        tick();
        check("midrst_idle", {30'd0, busy, done}, 32'd0);

        // Fresh run after the abandoned one
        exp_q.push_back(2);
        run_collect(8'h80, 0, 1'b0);
        wait_done("after_rst_done", 100);
        end_checks("after_rst", 8'h80, 1, 1'b0, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
